// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing the single register_file access port among
// NUM_REQ requesters. Supports locked bursts of up to MAX_LOCK beats and
// returns read data tagged with the id of the requester that issued it.
//
// Handshake: a requester beat is accepted on a rising edge where
// req_valid[i] & req_ready[i] are both high. req_ready is at most one-hot,
// may depend combinationally on req_valid, and is forced low during reset.
// Read responses present rsp_valid for exactly one cycle with no back-pressure.
module regfile_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_en,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_addr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [DATA_W-1:0]         rf_rdata,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [ID_W-1:0]    owner, owner_nxt;
    logic [CNT_W-1:0]   lock_cnt, cnt_nxt, cnt_inc;

    logic               arb_found;
    logic [ID_W-1:0]    arb_idx;
    logic [ID_W:0]      pos;
    logic [ID_W-1:0]    cand;

    logic [NUM_REQ-1:0] ready_c;
    logic [ID_W-1:0]    grant_idx;
    logic               accept;

    logic               rd_pend;
    logic [ID_W-1:0]    rd_id;

    // Next requester index after i, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
        if (i == ID_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + ID_W'(1);
    endfunction

    assign cnt_inc = lock_cnt + CNT_W'(1);

    // Round-robin search: first valid requester starting at ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        pos       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (ID_W + 1)'(k);
            if (pos >= (ID_W + 1)'(NUM_REQ)) begin
                pos = pos - (ID_W + 1)'(NUM_REQ);
            end
            cand = pos[ID_W-1:0];
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // FSM state register: arbitration mode, rotation pointer, lock owner and beat count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            ptr      <= '0;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            lock_cnt <= cnt_nxt;
        end
    end

    // FSM next state: enter a lock on a locked grant, leave it on release, idle owner or beat limit.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = lock_cnt;
        case (state)
            ARB: begin
                if (accept) begin
                    ptr_nxt = wrap_inc(grant_idx);
                    // With MAX_LOCK of 1 the single granted beat already exhausts the lock.
                    if (req_lock[grant_idx] && (MAX_LOCK > 1)) begin
                        state_nxt = LOCKED;
                        owner_nxt = grant_idx;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (accept && req_lock[owner] && (cnt_inc != CNT_W'(MAX_LOCK))) begin
                    cnt_nxt = cnt_inc;
                end else begin
                    // Release: voluntary, forced at MAX_LOCK, or owner went idle.
                    state_nxt = ARB;
                    ptr_nxt   = wrap_inc(owner);
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    // FSM outputs: ready vector and granted index; only the owner may be served while locked.
    always_comb begin
        ready_c   = '0;
        grant_idx = '0;
        if (!rst) begin
            case (state)
                ARB: begin
                    grant_idx = arb_idx;
                    if (arb_found) begin
                        ready_c[arb_idx] = 1'b1;
                    end
                end
                LOCKED: begin
                    grant_idx      = owner;
                    ready_c[owner] = req_valid[owner];
                end
                default: begin
                    ready_c = '0;
                end
            endcase
        end
        accept = |(ready_c & req_valid);
    end

    assign req_ready = ready_c;

    // Registered regfile drive and two-stage read-response tagging.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_en     <= 1'b0;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_wdata  <= '0;
            rd_pend   <= 1'b0;
            rd_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
        end else begin
            rf_en   <= accept;
            rd_pend <= accept & ~req_we[grant_idx];
            if (accept) begin
                rf_we    <= req_we[grant_idx];
                rf_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                rf_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
                rd_id    <= grant_idx;
            end
            rsp_valid <= rd_pend;
            if (rd_pend) begin
                rsp_id <= rd_id;
            end
        end
    end

    // Read data is returned straight from the regfile in the response cycle.
    assign rsp_rdata = rf_rdata;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter: each stimulus step pushes the
// hand-computed grant, regfile access and read response into queues that a
// negedge monitor pops whenever the DUT presents the corresponding output.
module tb_regfile_port_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int MAX_LOCK = 8;
    localparam int ID_W     = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rf_en;
    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_addr;
    logic [DATA_W-1:0]         rf_wdata;
    logic [DATA_W-1:0]         rf_rdata;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_rdata;

    regfile_port_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rf_en     (rf_en),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata)
    );

    // Per-requester payload configured by each test.
    logic [ADDR_W-1:0] addr_cfg  [NUM_REQ];
    logic [DATA_W-1:0] wdata_cfg [NUM_REQ];
    logic [NUM_REQ-1:0] we_cfg;
    bit                 rsp_en;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W]  = addr_cfg[i];
            req_wdata[i*DATA_W +: DATA_W] = wdata_cfg[i];
        end
        req_we = we_cfg;
    end

    // Fixed read pattern of the regfile model.
    function automatic logic [DATA_W-1:0] rd_pattern(input logic [ADDR_W-1:0] a);
        if (a == 5'd5) return 32'hDEADBEEF;
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // Regfile model: read data valid one cycle after a read strobe.
    always @(posedge clk) begin
        if (rf_en && !rf_we) rf_rdata <= rd_pattern(rf_addr);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [ID_W-1:0]          grant_q [$];
    logic [ADDR_W+DATA_W:0]   rf_q    [$];
    logic [ID_W+DATA_W-1:0]   rsp_q   [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h expected=none", name, act);
    endtask

    // Monitor: compare every accepted beat, regfile access and response.
    always @(negedge clk) begin
        logic [ID_W-1:0] gid;
        gid = '0;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gid = ID_W'(i);
        if (|(req_valid & req_ready)) begin
            check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
            if (grant_q.size() == 0) unexpected("grant", 64'(gid));
            else check("grant", 64'(gid), 64'(grant_q.pop_front()));
        end
        if (rf_en === 1'b1) begin
            if (rf_q.size() == 0) unexpected("rf_access", 64'({rf_we, rf_addr, rf_wdata}));
            else check("rf_access", 64'({rf_we, rf_addr, rf_wdata}), 64'(rf_q.pop_front()));
        end
        if (rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) unexpected("rsp", 64'({rsp_id, rsp_rdata}));
            else check("rsp", 64'({rsp_id, rsp_rdata}), 64'(rsp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    // Present one cycle of requests; exp_g is the requester that must win (-1: none).
    task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] l, input int exp_g);
        req_valid = v;
        req_lock  = l;
        if (exp_g >= 0) begin
            grant_q.push_back(ID_W'(exp_g));
            rf_q.push_back({we_cfg[exp_g], addr_cfg[exp_g], wdata_cfg[exp_g]});
            if (!we_cfg[exp_g] && rsp_en)
                rsp_q.push_back({ID_W'(exp_g), rd_pattern(addr_cfg[exp_g])});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int n);
        req_valid = '0;
        req_lock  = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        check(name, 64'(grant_q.size() + rf_q.size() + rsp_q.size()), 64'd0);
    endtask

    task automatic config_reqs(input logic [NUM_REQ-1:0] we, input logic [ADDR_W-1:0] abase,
                               input logic [DATA_W-1:0] dbase);
        we_cfg = we;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_cfg[i]  = abase + ADDR_W'(i);
            wdata_cfg[i] = dbase + DATA_W'(i);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        req_lock  = '0;
        rsp_en    = 1'b1;
        config_reqs(4'b0101, 5'd8, 32'h5000_0000);

        // T1: reset held two cycles with all requests pending.
        @(negedge clk);
        check("t1_ready", 64'(req_ready), 64'd0);
        check("t1_rf_en", 64'(rf_en), 64'd0);
        check("t1_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t1_rf_addr", 64'(rf_addr), 64'd0);
        check("t1_rsp_id", 64'(rsp_id), 64'd0);
        @(negedge clk);
        check("t1_ready2", 64'(req_ready), 64'd0);
        check("t1_rf_en2", 64'(rf_en), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // T2: all requesters, no lock: rotation 0,1,2,3,0,1 (1 and 3 are reads).
        step(4'hF, 4'h0, 0);
        step(4'hF, 4'h0, 1);
        step(4'hF, 4'h0, 2);
        step(4'hF, 4'h0, 3);
        step(4'hF, 4'h0, 0);
        step(4'hF, 4'h0, 1);
        drain("t2_drain", 4);

        // T3: req2 reads addr 5; access at N+1, tagged response at N+2.
        we_cfg[2]   = 1'b0;
        addr_cfg[2] = 5'd5;
        step(4'b0100, 4'h0, 2);
        check("t3_rf_en", 64'(rf_en), 64'd1);
        check("t3_rf_addr", 64'(rf_addr), 64'd5);
        req_valid = '0;
        @(posedge clk);
        #1;
        check("t3_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t3_rsp_id", 64'(rsp_id), 64'd2);
        check("t3_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        drain("t3_drain", 3);

        // T4: req1 locks three beats while req0/req2 wait: 1,1,1,2,0.
        config_reqs(4'b1111, 5'd16, 32'hA4A4_0000);
        step(4'b0010, 4'b0010, 1);
        step(4'b0111, 4'b0010, 1);
        step(4'b0111, 4'b0000, 1);
        step(4'b0101, 4'b0000, 2);
        step(4'b0001, 4'b0000, 0);
        drain("t4_drain", 3);

        // T5: req3 holds lock; forced release after 8 beats, req0 served, req3 relocks.
        config_reqs(4'b1110, 5'd24, 32'hB5B5_0000);
        step(4'b1000, 4'b1000, 3);
        for (int c = 1; c < MAX_LOCK; c++) step(4'b1001, 4'b1000, 3);
        step(4'b1001, 4'b1000, 0);
        for (int c = 0; c < 4; c++) step(4'b1000, 4'b1000, 3);
        step(4'b0000, 4'b0000, -1);
        step(4'b0001, 4'b0000, 0);
        drain("t5_drain", 4);

        // T6: reset right after a read is accepted drops the response.
        config_reqs(4'b0000, 5'd3, 32'h0);
        rsp_en = 1'b0;
        step(4'b0001, 4'b0000, 0);
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t6_rf_en", 64'(rf_en), 64'd0);
        drain("t6_drain", 3);
        rsp_en = 1'b1;
        // Pointer is back at 0 after reset: req1 wins over req3.
        step(4'b1010, 4'b0000, 1);
        drain("t6_post_drain", 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
